// File: rtl/tx_block_scheduler.sv
// tx_block_scheduler: feeds a 32-bit TX gearbox from two 64b/66b requesters
// (A = data blocks, header 01; B = control blocks, header 10). Each block is
// sent as two 32-bit halves paced by i_data_rdy. Requesters are served
// round-robin, and an idle block is inserted when nobody requests.
// A one-cycle start pulse is issued START_DELAY cycles after reset release.
// Optional feature macro: TX_BLOCK_SCHEDULER_SCRAMBLER_EN scrambles every
// loaded payload with x^58+x^39+1. The header is never scrambled.
module tx_block_scheduler #(
    parameter int          START_DELAY  = 16,
    parameter logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E
) (
    input  logic        i_usrclk2,
    input  logic        i_rst_n,
    output logic        o_startseq,
    input  logic        i_data_rdy,
    output logic [1:0]  o_header,
    output logic [31:0] o_data,
    input  logic        i_a_valid,
    input  logic [63:0] i_a_payload,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [63:0] i_b_payload,
    output logic        o_b_ready,
    output logic [31:0] o_blocks_sent,
    output logic [31:0] o_idle_inserted
);

    localparam logic [1:0]  HDR_DATA    = 2'b01;
    localparam logic [1:0]  HDR_CTRL    = 2'b10;
    localparam logic [15:0] START_LIMIT = 16'(START_DELAY);

    // ST_STARTUP waits for the start pulse; ST_LOW/ST_HIGH present the halves
    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_LOW,
        ST_HIGH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] start_cnt;
    logic        start_hit;
    logic        startseq;
    logic [1:0]  hold_header;
    logic [63:0] hold_payload;
    logic        last_grant_a;
    logic        load_edge;
    logic        grant_a;
    logic        grant_b;
    logic [1:0]  load_header;
    logic [63:0] raw_payload;
    logic [63:0] load_payload;
    logic [31:0] blocks_sent;
    logic [31:0] idle_inserted;

    assign start_hit = (start_cnt + 16'd1) == START_LIMIT;

    // State register for the startup / half-sequencing FSM
    always_ff @(posedge i_usrclk2) begin
        if (!i_rst_n) begin
            state <= ST_STARTUP;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave startup on the start cycle, then toggle halves on data-ready
    always_comb begin
        state_next = state;
        case (state)
            ST_STARTUP: if (start_hit)  state_next = ST_LOW;
            ST_LOW:     if (i_data_rdy) state_next = ST_HIGH;
            ST_HIGH:    if (i_data_rdy) state_next = ST_LOW;
            default:    state_next = ST_STARTUP;
        endcase
    end

    // Round-robin grant and block selection, evaluated only on the load edge
    always_comb begin
        load_edge   = i_rst_n && (state == ST_HIGH) && i_data_rdy;
        grant_a     = load_edge && i_a_valid && (!i_b_valid || !last_grant_a);
        grant_b     = load_edge && i_b_valid && (!i_a_valid || last_grant_a);
        load_header = HDR_CTRL;
        raw_payload = IDLE_PAYLOAD;
        if (grant_a) begin
            load_header = HDR_DATA;
            raw_payload = i_a_payload;
        end else if (grant_b) begin
            raw_payload = i_b_payload;
        end
    end

`ifdef TX_BLOCK_SCHEDULER_SCRAMBLER_EN
    logic [57:0] scr_state;
    logic [57:0] scr_next;
    logic [57:0] scr_work;
    logic        scr_bit;

    // Full 64-bit scrambler step, LSB first, computed for the block being loaded
    always_comb begin
        scr_work     = scr_state;
        scr_bit      = 1'b0;
        load_payload = '0;
        for (int i = 0; i < 64; i++) begin
            scr_bit         = raw_payload[i] ^ scr_work[38] ^ scr_work[57];
            load_payload[i] = scr_bit;
            scr_work        = {scr_work[56:0], scr_bit};
        end
        scr_next = scr_work;
    end

    // Scrambler state advances only when a block is actually loaded
    always_ff @(posedge i_usrclk2) begin
        if (!i_rst_n) begin
            scr_state <= 58'h3FF_FFFF_FFFF_FFFF;
        end else if (load_edge) begin
            scr_state <= scr_next;
        end
    end
`else
    assign load_payload = raw_payload;
`endif

    // Startup counter, start pulse, holding register, RR pointer and statistics
    always_ff @(posedge i_usrclk2) begin
        if (!i_rst_n) begin
            start_cnt     <= '0;
            startseq      <= 1'b0;
            hold_header   <= HDR_CTRL;
            hold_payload  <= IDLE_PAYLOAD;
            last_grant_a  <= 1'b0;
            blocks_sent   <= '0;
            idle_inserted <= '0;
        end else begin
            startseq <= (state == ST_STARTUP) && start_hit;
            if (state == ST_STARTUP) begin
                start_cnt <= start_cnt + 16'd1;
            end
            if (load_edge) begin
                hold_header  <= load_header;
                hold_payload <= load_payload;
                blocks_sent  <= blocks_sent + 32'd1;
                if (grant_a) begin
                    last_grant_a <= 1'b1;
                end else if (grant_b) begin
                    last_grant_a <= 1'b0;
                end else begin
                    idle_inserted <= idle_inserted + 32'd1;
                end
            end
        end
    end

    assign o_startseq      = startseq;
    assign o_header        = hold_header;
    assign o_data          = (state == ST_HIGH) ? hold_payload[63:32] : hold_payload[31:0];
    assign o_a_ready       = grant_a;
    assign o_b_ready       = grant_b;
    assign o_blocks_sent   = blocks_sent;
    assign o_idle_inserted = idle_inserted;

endmodule

// File: tb/tb_tx_block_scheduler.sv
// tb_tx_block_scheduler: randomized and directed stimulus for tx_block_scheduler.
// A reference model predicts grants and the half-word stream. A separate monitor
// pops the expected halves as the gearbox consumes them.
module tb_tx_block_scheduler;

    localparam int          START_DELAY  = 16;
    localparam logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E;

    localparam int MODE_IDLE    = 0;
    localparam int MODE_A_FIXED = 1;
    localparam int MODE_BOTH    = 2;
    localparam int MODE_STALL   = 3;
    localparam int MODE_RANDOM  = 4;

    localparam int SIDE_NONE = 0;
    localparam int SIDE_A    = 1;
    localparam int SIDE_B    = 2;
    localparam int SIDE_IDLE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        startseq;
    logic        data_rdy;
    logic [1:0]  header;
    logic [31:0] data;
    logic        a_valid;
    logic [63:0] a_payload;
    logic        a_ready;
    logic        b_valid;
    logic [63:0] b_payload;
    logic        b_ready;
    logic [31:0] blocks_sent;
    logic [31:0] idle_inserted;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [31:0] data;
    } half_t;

    half_t exp_q[$];

    // reference model state (describes the cycle currently presented)
    int          m_cnt       = 0;
    bit          m_started   = 1'b0;
    int          m_half      = 0;
    int          m_last      = SIDE_NONE;
    int unsigned m_sent      = 0;
    int unsigned m_idle      = 0;
    bit          exp_startseq = 1'b0;
`ifdef TX_BLOCK_SCHEDULER_SCRAMBLER_EN
    bit          m_hist[$];
`endif

    // handshake between the predictor, the edge model and the monitor
    bit sb_active    = 1'b0;
    bit consumed_evt = 1'b0;
    bit pend_rst     = 1'b1;
    bit pend_rdy     = 1'b0;
    int pend_side    = SIDE_NONE;

    // requester-side driver state
    bit          a_pend = 1'b0;
    bit          b_pend = 1'b0;
    bit          a_seen = 1'b0;
    bit          b_seen = 1'b0;
    logic [63:0] a_pay  = '0;
    logic [63:0] b_pay  = '0;

    tx_block_scheduler #(
        .START_DELAY (START_DELAY),
        .IDLE_PAYLOAD(IDLE_PAYLOAD)
    ) dut (
        .i_usrclk2      (clk),
        .i_rst_n        (rst_n),
        .o_startseq     (startseq),
        .i_data_rdy     (data_rdy),
        .o_header       (header),
        .o_data         (data),
        .i_a_valid      (a_valid),
        .i_a_payload    (a_payload),
        .o_a_ready      (a_ready),
        .i_b_valid      (b_valid),
        .i_b_payload    (b_payload),
        .o_b_ready      (b_ready),
        .o_blocks_sent  (blocks_sent),
        .o_idle_inserted(idle_inserted)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expected);
        compared++;
        if (got !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, expected);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

`ifdef TX_BLOCK_SCHEDULER_SCRAMBLER_EN
    // Self-synchronous scrambler as a bit history: each output bit also depends on
    // the outputs produced 39 and 58 bits earlier
    function automatic logic [63:0] scrambleModel(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = d[i] ^ m_hist[m_hist.size() - 39] ^ m_hist[m_hist.size() - 58];
            m_hist.push_back(r[i]);
            void'(m_hist.pop_front());
        end
        return r;
    endfunction
`endif

    // Predict what happens at the coming edge; queue any block that will be loaded
    task automatic predictEdge();
        int          side;
        bit          load;
        logic [1:0]  hdr;
        logic [63:0] pay;
        side     = SIDE_NONE;
        pend_rst = !rst_n;
        pend_rdy = data_rdy;
        load     = rst_n && m_started && (m_half == 1) && data_rdy;
        if (load) begin
            if (a_valid && b_valid)  side = (m_last == SIDE_A) ? SIDE_B : SIDE_A;
            else if (a_valid)        side = SIDE_A;
            else if (b_valid)        side = SIDE_B;
            else                     side = SIDE_IDLE;
            hdr = (side == SIDE_A) ? 2'b01 : 2'b10;
            if (side == SIDE_A)      pay = a_payload;
            else if (side == SIDE_B) pay = b_payload;
            else                     pay = IDLE_PAYLOAD;
`ifdef TX_BLOCK_SCHEDULER_SCRAMBLER_EN
            pay = scrambleModel(pay);
`endif
            exp_q.push_back({hdr, pay[31:0]});
            exp_q.push_back({hdr, pay[63:32]});
        end
        pend_side = side;
        if (sb_active) begin
            checkOutput("a_ready", {63'd0, a_ready}, {63'd0, side == SIDE_A});
            checkOutput("b_ready", {63'd0, b_ready}, {63'd0, side == SIDE_B});
        end
    endtask

    // Apply the edge that just happened to the model, then check registered outputs
    task automatic applyEdge();
        if (pend_rst) begin
            m_cnt        = 0;
            m_started    = 1'b0;
            m_half       = 0;
            m_last       = SIDE_NONE;
            m_sent       = 0;
            m_idle       = 0;
            exp_startseq = 1'b0;
`ifdef TX_BLOCK_SCHEDULER_SCRAMBLER_EN
            m_hist.delete();
            repeat (58) m_hist.push_back(1'b1);
`endif
            exp_q.delete();
            exp_q.push_back({2'b10, IDLE_PAYLOAD[31:0]});
            exp_q.push_back({2'b10, IDLE_PAYLOAD[63:32]});
            consumed_evt = 1'b0;
            sb_active    = 1'b1;
        end else begin
            consumed_evt = m_started && pend_rdy;
            exp_startseq = 1'b0;
            if (!m_started) begin
                m_cnt++;
                if (m_cnt == START_DELAY) begin
                    m_started    = 1'b1;
                    exp_startseq = 1'b1;
                end
            end else if (pend_rdy) begin
                if (m_half == 0) begin
                    m_half = 1;
                end else begin
                    m_half = 0;
                    m_sent++;
                    if (pend_side == SIDE_IDLE) m_idle++;
                    else                        m_last = pend_side;
                end
            end
        end
        if (sb_active) begin
            checkOutput("startseq", {63'd0, startseq}, {63'd0, exp_startseq});
            checkOutput("blocks_sent", {32'd0, blocks_sent}, {32'd0, m_sent});
            checkOutput("idle_inserted", {32'd0, idle_inserted}, {32'd0, m_idle});
        end
    endtask

    // Monitor: retire consumed halves and compare the presented half with the queue head
    task automatic checkData();
        if (!sb_active) return;
        if (consumed_evt) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL consume at %0t: got empty scoreboard, expected a queued half", $time);
            end else begin
                void'(exp_q.pop_front());
            end
        end
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL data at %0t: got %h with empty scoreboard, expected a queued half", $time, data);
        end else begin
            checkOutput("header", {62'd0, header}, {62'd0, exp_q[0].hdr});
            checkOutput("data", {32'd0, data}, {32'd0, exp_q[0].data});
        end
    endtask

    initial forever begin
        @(negedge clk);
        #4;
        predictEdge();
    end

    initial forever begin
        @(posedge clk);
        #1;
        applyEdge();
    end

    initial forever begin
        @(posedge clk);
        #2;
        checkData();
    end

    // Drive requesters and data-ready at the falling edge; note readies just before the rising edge
    task automatic applyStimulus(input int cycles, input int mode, input bit rst_val);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst_n = rst_val;
            if (a_seen) a_pend = 1'b0;
            if (b_seen) b_pend = 1'b0;
            case (mode)
                MODE_IDLE: begin
                    a_pend   = 1'b0;
                    b_pend   = 1'b0;
                    data_rdy = 1'b1;
                end
                MODE_A_FIXED: begin
                    if (!a_pend) begin
                        a_pend = 1'b1;
                        a_pay  = 64'h1111_2222_3333_4444;
                    end
                    b_pend   = 1'b0;
                    data_rdy = 1'b1;
                end
                MODE_BOTH: begin
                    if (!a_pend) begin
                        a_pend = 1'b1;
                        a_pay  = rand64();
                    end
                    if (!b_pend) begin
                        b_pend = 1'b1;
                        b_pay  = rand64();
                    end
                    data_rdy = 1'b1;
                end
                MODE_STALL: begin
                    if (!a_pend) begin
                        a_pend = 1'b1;
                        a_pay  = rand64();
                    end
                    b_pend   = 1'b0;
                    data_rdy = (c % 7) >= 3;
                end
                default: begin
                    if (!a_pend && $urandom_range(0, 1) == 1) begin
                        a_pend = 1'b1;
                        a_pay  = rand64();
                    end else if (a_pend && $urandom_range(0, 15) == 0) begin
                        a_pend = 1'b0;
                    end
                    if (!b_pend && $urandom_range(0, 1) == 1) begin
                        b_pend = 1'b1;
                        b_pay  = rand64();
                    end else if (b_pend && $urandom_range(0, 15) == 0) begin
                        b_pend = 1'b0;
                    end
                    data_rdy = $urandom_range(0, 3) != 0;
                end
            endcase
            a_valid   = a_pend;
            a_payload = a_pay;
            b_valid   = b_pend;
            b_payload = b_pay;
            #4;
            a_seen = a_ready;
            b_seen = b_ready;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        data_rdy  = 1'b0;
        a_valid   = 1'b0;
        a_payload = '0;
        b_valid   = 1'b0;
        b_payload = '0;
        $display("[TB] start");
        applyStimulus(3, MODE_IDLE, 1'b0);
        applyStimulus(START_DELAY + 4, MODE_IDLE, 1'b1);
        applyStimulus(20, MODE_IDLE, 1'b1);
        applyStimulus(8, MODE_A_FIXED, 1'b1);
        applyStimulus(70, MODE_STALL, 1'b1);
        applyStimulus(60, MODE_BOTH, 1'b1);
        applyStimulus(1500, MODE_RANDOM, 1'b1);
        applyStimulus(2, MODE_RANDOM, 1'b0);
        applyStimulus(600, MODE_RANDOM, 1'b1);
        applyStimulus(6, MODE_IDLE, 1'b1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
